// File: rtl/imm_encoder.sv
// imm_encoder
//   Packs a major opcode (instr[6:2]), a signed immediate and the register /
//   funct3 fields into a full RV32I instruction word. It also range-checks the
//   immediate against the selected format (I, S, B or J). The datapath is a
//   two-stage valid/ready pipeline with a throughput of one beat per cycle.
//
//   Build option: define ROUNDTRIP_CHECK_EN to add a stage-2 checker. The
//   checker re-extracts the immediate from the packed word, flags a mismatch
//   on rt_mismatch, and forces out_err on that beat.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake
//   in_op               major opcode instr[6:2]
//   in_imm              signed immediate (byte offset for B/J)
//   in_rd/rs1/rs2       register fields
//   in_funct3           funct3 field
//   out_valid/out_ready output handshake
//   out_instr           packed instruction (NOP for unsupported opcodes)
//   out_err             immediate unencodable or opcode unsupported
//   rt_mismatch         round-trip checker mismatch (ROUNDTRIP_CHECK_EN only)
//   err_cnt             saturating count of delivered errored beats
//   err_clr             synchronous clear of err_cnt (wins over increment)
module imm_encoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_op,
    input  logic signed [31:0]   in_imm,
    input  logic [4:0]           in_rd,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [2:0]           in_funct3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
`ifdef ROUNDTRIP_CHECK_EN
    output logic                 rt_mismatch,
`endif
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_J, FMT_NONE} fmt_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic fmt_t decode_fmt(input logic [4:0] op);
        casez (op)
            5'b00?00: return FMT_I;
            5'b01000: return FMT_S;
            5'b11000: return FMT_B;
            5'b11011: return FMT_J;
            default:  return FMT_NONE;
        endcase
    endfunction

    // The immediate must be representable as a sign-extended field of the
    // format's width; B/J offsets must also be halfword aligned.
    function automatic logic imm_legal(input fmt_t fmt, input logic signed [31:0] imm);
        case (fmt)
            FMT_I, FMT_S: return (&imm[31:11]) | ~(|imm[31:11]);
            FMT_B:        return ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            FMT_J:        return ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            default:      return 1'b0;
        endcase
    endfunction

    // Only imm[20:0] ever reaches an instruction field, so stage 1 keeps just those.
    function automatic logic [31:0] pack_instr(input fmt_t fmt, input logic [4:0] op,
                                               input logic signed [20:0] imm,
                                               input logic [4:0] rd, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [2:0] f3);
        case (fmt)
            FMT_I:   return {imm[11:0], rs1, f3, rd, op, 2'b11};
            FMT_S:   return {imm[11:5], rs2, rs1, f3, imm[4:0], op, 2'b11};
            FMT_B:   return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op, 2'b11};
            FMT_J:   return {imm[20], imm[10:1], imm[11], imm[19:12], rd, op, 2'b11};
            default: return NOP;
        endcase
    endfunction

`ifdef ROUNDTRIP_CHECK_EN
    function automatic logic signed [31:0] extract_imm(input fmt_t fmt, input logic [31:0] w);
        case (fmt)
            FMT_I:   return {{20{w[31]}}, w[31:20]};
            FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'sd0;
        endcase
    endfunction

    function automatic logic signed [31:0] format_imm(input fmt_t fmt, input logic signed [20:0] imm);
        case (fmt)
            FMT_I, FMT_S: return {{20{imm[11]}}, imm[11:0]};
            FMT_B:        return {{19{imm[12]}}, imm[12:1], 1'b0};
            FMT_J:        return {{11{imm[20]}}, imm[20:1], 1'b0};
            default:      return 32'sd0;
        endcase
    endfunction
`endif

    logic                vld_p1, vld_p2;
    logic                adv_p1, adv_p2;
    fmt_t                fmt_d;
    logic                legal_d;

    fmt_t                fmt_p1;
    logic                legal_p1;
    logic [4:0]          op_p1, rd_p1, rs1_p1, rs2_p1;
    logic [2:0]          f3_p1;
    logic signed [20:0]  imm_p1;

    logic [31:0]         instr_d2;
    logic                err_d2;
    logic [31:0]         instr_p2;
    logic                err_p2;

    assign adv_p2   = ~vld_p2 | out_ready;
    assign adv_p1   = ~vld_p1 | adv_p2;
    assign in_ready = adv_p1;

    assign fmt_d   = decode_fmt(in_op);
    assign legal_d = imm_legal(fmt_d, in_imm);

    // ---- stage 1: capture fields, decoded format and legality ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && adv_p1) begin
            fmt_p1   <= fmt_d;
            legal_p1 <= legal_d;
            op_p1    <= in_op;
            imm_p1   <= in_imm[20:0];
            rd_p1    <= in_rd;
            rs1_p1   <= in_rs1;
            rs2_p1   <= in_rs2;
            f3_p1    <= in_funct3;
        end
    end

    assign instr_d2 = pack_instr(fmt_p1, op_p1, imm_p1, rd_p1, rs1_p1, rs2_p1, f3_p1);

`ifdef ROUNDTRIP_CHECK_EN
    logic rt_bad_d2;
    logic rt_p2;
    assign rt_bad_d2 = legal_p1 && (extract_imm(fmt_p1, instr_d2) != format_imm(fmt_p1, imm_p1));
    assign err_d2    = ~legal_p1 | rt_bad_d2;
`else
    assign err_d2    = ~legal_p1;
`endif

    // ---- stage 2: registered instruction word and error flag ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            instr_p2 <= '0;
            err_p2   <= 1'b0;
`ifdef ROUNDTRIP_CHECK_EN
            rt_p2    <= 1'b0;
`endif
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                instr_p2 <= instr_d2;
                err_p2   <= err_d2;
`ifdef ROUNDTRIP_CHECK_EN
                rt_p2    <= rt_bad_d2;
`endif
            end
        end
    end

    assign out_valid = vld_p2;
    assign out_instr = instr_p2;
    assign out_err   = err_p2;
`ifdef ROUNDTRIP_CHECK_EN
    assign rt_mismatch = rt_p2;
`endif

    // ---- error counter: counts delivered errored beats, clear wins ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (vld_p2 && out_ready && err_p2 && !(&err_cnt)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder
//   Directed-vector bench for imm_encoder: per-format packing, error flags,
//   error counter clear/saturation, backpressure ordering and mid-flight reset.
module tb_imm_encoder;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [4:0]         in_op = '0;
    logic signed [31:0] in_imm = '0;
    logic [4:0]         in_rd = '0;
    logic [4:0]         in_rs1 = '0;
    logic [4:0]         in_rs2 = '0;
    logic [2:0]         in_funct3 = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [31:0]        out_instr;
    logic               out_err;
`ifdef ROUNDTRIP_CHECK_EN
    logic               rt_mismatch;
`endif
    logic [7:0]         err_cnt;
    logic               err_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    imm_encoder #(.ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_err    (out_err),
`ifdef ROUNDTRIP_CHECK_EN
        .rt_mismatch(rt_mismatch),
`endif
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [4:0] op, input logic signed [31:0] imm,
                            input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3);
        in_op = op; in_imm = imm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3;
    endtask

    // One beat through an empty pipeline with out_ready=1; checks the
    // 2-cycle latency, then lets the output transfer happen.
    task automatic run_one(input string tag, input logic [4:0] op, input logic signed [31:0] imm,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [31:0] exp_instr, input logic exp_err);
        out_ready = 1'b1;
        set_beat(op, imm, rd, rs1, rs2, f3);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1_vld"}, {31'd0, out_valid}, 32'd0);
        step();
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_instr"}, out_instr, exp_instr);
        chk({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
        step();
    endtask

    initial begin
        logic [31:0] exp_q [5];
        logic [3:0]  pat;
        logic [31:0] held_v;
        int          tx, rx, stale;
        bit          saw_full, held;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_err", {31'd0, out_err}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Per-format packing
        run_one("i_type", 5'b00100, 32'hFFFF_FFFF, 5'd1, 5'd0, 5'd0, 3'd0, 32'hFFF0_0093, 1'b0);
        run_one("s_type", 5'b01000, 32'sd8,        5'd0, 5'd1, 5'd2, 3'b010, 32'h0020_A423, 1'b0);
        run_one("b_type", 5'b11000, -32'sd4,       5'd0, 5'd0, 5'd0, 3'd0, 32'hFE00_0EE3, 1'b0);
        run_one("j_type", 5'b11011, 32'h800,       5'd1, 5'd7, 5'd9, 3'd5, 32'h0010_00EF, 1'b0);
        // Boundary legal I immediates: -2048 and 2047
        run_one("i_min", 5'b00000, -32'sd2048, 5'd2, 5'd3, 5'd0, 3'd1, 32'h8001_9103, 1'b0);
        run_one("i_max", 5'b00100, 32'sd2047,  5'd2, 5'd3, 5'd0, 3'd1, 32'h7FF1_9113, 1'b0);
        chk("cnt_after_legal", {24'd0, err_cnt}, 32'd0);

        // Error beats: B odd offset (truncated fields still packed), I out of range, unsupported op
        run_one("b_odd", 5'b11000, 32'sd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0163, 1'b1);
        run_one("i_2048", 5'b00100, 32'sd2048, 5'd1, 5'd0, 5'd0, 3'd0, 32'h8000_0093, 1'b1);
        run_one("op_unsup", 5'b01100, 32'sd5, 5'd1, 5'd2, 5'd3, 3'd0, 32'h0000_0013, 1'b1);
        chk("cnt_three", {24'd0, err_cnt}, 32'd3);

        // Clear has priority over a same-cycle errored transfer
        set_beat(5'b01100, 32'sd0, 5'd0, 5'd0, 5'd0, 3'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("clrprio_vld", {31'd0, out_valid}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_priority", {24'd0, err_cnt}, 32'd0);

        // Plain clear
        run_one("one_err", 5'b11011, 32'sd2, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0020_006F, 1'b0);
        run_one("j_odd", 5'b11011, 32'sd1, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_006F, 1'b1);
        chk("cnt_one", {24'd0, err_cnt}, 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("cnt_clr", {24'd0, err_cnt}, 32'd0);

        // Saturation: 300 errored beats at full throughput
        out_ready = 1'b1;
        set_beat(5'b01100, 32'sd0, 5'd0, 5'd0, 5'd0, 3'd0);
        in_valid = 1'b1;
        repeat (300) step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("cnt_saturate", {24'd0, err_cnt}, 32'd255);

        // Backpressure: 5 legal I beats, out_ready pattern 1,0,0,1
        for (int i = 0; i < 5; i++)
            exp_q[i] = (32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13;
        pat = 4'b1001;
        tx = 0; rx = 0; saw_full = 0; held = 0; held_v = '0;
        for (int c = 0; c < 100 && rx < 5; c++) begin
            out_ready = pat[c % 4];
            if (tx < 5) begin
                set_beat(5'b00100, 32'(tx + 1), 5'(tx + 1), 5'd0, 5'd0, 3'd0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (held) begin
                chk("bp_hold_vld", {31'd0, out_valid}, 32'd1);
                chk("bp_hold_instr", out_instr, held_v);
            end
            if (!in_ready) saw_full = 1;
            held   = out_valid && !out_ready;
            held_v = out_instr;
            if (out_valid && out_ready) begin
                chk("bp_order", out_instr, exp_q[rx]);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_rx_count", 32'(rx), 32'd5);
        chk("bp_saw_full", {31'd0, saw_full}, 32'd1);
        out_ready = 1'b1;
        stale = 0;
        repeat (4) begin
            step();
            if (out_valid) stale++;
        end
        chk("bp_no_dup", 32'(stale), 32'd0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        set_beat(5'b00100, 32'sd1, 5'd1, 5'd0, 5'd0, 3'd0);
        in_valid = 1'b1;
        step();
        set_beat(5'b00100, 32'sd2, 5'd2, 5'd0, 5'd0, 3'd0);
        step();
        in_valid = 1'b0;
        chk("mid_rst_pre_vld", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_cnt", {24'd0, err_cnt}, 32'd0);
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            step();
            if (out_valid) stale++;
        end
        chk("mid_rst_no_stale", 32'(stale), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
